// File: rtl/sb_pkg.sv
// Register scoreboard shared types and defaults.
// Defaults for address width, register count, sources and writer depth.
package sb_pkg;

  localparam int SB_AW           = 5;
  localparam int SB_NREG         = 2 ** SB_AW;
  localparam int SB_NSRC         = 2;
  localparam int SB_MAX_INFLIGHT = 3;
  localparam int SB_CW           = $clog2(SB_MAX_INFLIGHT + 1);

  localparam int SB_UNTRACKED = -1;

  // r0 is hard-wired, so it never owns a pending counter.
  function automatic int pend_idx(input int addr);
    return (addr == 0) ? SB_UNTRACKED : addr;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Saturating pending-writer counter for one register.
// Flags over/underflow attempts instead of wrapping.
module sb_counter #(
  parameter int CW  = 2,
  parameter int MAX = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          nonzero,
  output logic          at_max,
  output logic          err_pulse
);

  logic up;
  logic down;

  assign up        = inc && !dec;
  assign down      = dec && !inc;
  assign nonzero   = (count != '0);
  assign at_max    = (count == CW'(MAX));
  assign err_pulse = !clr && ((up && at_max) || (down && !nonzero));

  // Count writers; clear wins, saturate at both ends.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (up && !at_max) begin
      count <= count + 1'b1;
    end else if (down && nonzero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage register scoreboard with per-register writer counts.
// Optional stall statistics when SB_STATS_EN is defined.
module reg_scoreboard
  import sb_pkg::*;
#(
  parameter int AW           = SB_AW,
  parameter int NREG         = SB_NREG,
  parameter int NSRC         = SB_NSRC,
  parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            ds_valid,
  input  logic [NSRC-1:0] rd_used,
  input  logic [NSRC*AW-1:0] rd_addr,
  input  logic            is_fire,
  input  logic            is_we,
  input  logic [AW-1:0]   is_dest,
  input  logic            wb_fire,
  input  logic [AW-1:0]   wb_dest,
  input  logic            flush,
  output logic            stall,
  output logic [NREG-1:0] busy_vec,
  output logic            sb_err
`ifdef SB_STATS_EN
 ,output logic [31:0]     stall_cycles
`endif
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  logic [CW-1:0]   pend [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] full;
  logic [NREG-1:0] err_vec;
  logic            src_hz;
  logic            cap_hz;
  logic            fire_err;
  int              idx;

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign pend[r]    = '0;
      assign busy[r]    = 1'b0;
      assign full[r]    = 1'b0;
      assign err_vec[r] = 1'b0;
    end else begin : g_cnt
      logic inc;
      logic dec;
      assign inc = is_fire && is_we && (is_dest == AW'(r));
      assign dec = wb_fire && (wb_dest == AW'(r));
      sb_counter #(
        .CW  (CW),
        .MAX (MAX_INFLIGHT)
      ) u_cnt (
        .clk       (clk),
        .resetn    (resetn),
        .inc       (inc),
        .dec       (dec),
        .clr       (flush),
        .count     (pend[r]),
        .nonzero   (busy[r]),
        .at_max    (full[r]),
        .err_pulse (err_vec[r])
      );
    end
  end

  // Any read source with an outstanding writer blocks decode.
  always_comb begin
    src_hz = 1'b0;
    idx    = 0;
    for (int i = 0; i < NSRC; i++) begin
      idx = pend_idx(int'(rd_addr[i*AW +: AW]));
      if (rd_used[i] && idx != SB_UNTRACKED &&
          pend[AW'(idx)] != '0) begin
        src_hz = 1'b1;
      end
    end
  end

  assign cap_hz   = is_we && (is_dest != '0) && full[is_dest];
  assign stall    = ds_valid && (src_hz || cap_hz);
  assign busy_vec = busy;
  assign fire_err = is_fire && stall && !flush;

  // Sticky protocol error; only reset clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sb_err <= 1'b0;
    end else if (fire_err || (|err_vec)) begin
      sb_err <= 1'b1;
    end
  end

`ifdef SB_STATS_EN
  // Free-running stall cycle counter, wraps naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cycles <= '0;
    end else if (stall) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
